serial_loader: RTL
==================

Name: serial_loader

Overview:
- UART-driven programmer that writes into PRG-ROM, CHR-ROM and CPU RAM over SERIAL_RX/SERIAL_TX. Lets a new cartridge image be loaded into the board without resynthesis.
- Holds the CPU in reset while loading.
- Sits at board top level next to the memory instances. Its write strobes are muxed into the memory write ports. `cpu_hold` gates the CPU `reset_n`.

Parameters:
- CLK_DIV, 217, clock cycles per UART bit (25 MHz / 115200).
- TIMEOUT, 2500000, idle cycles mid-frame before the frame is abandoned (100 ms at 25 MHz).

Ports:
- clock  in  1  system clock (clock_25 domain)
- reset  in  1  synchronous, active-high reset
- rx  in  1  UART receive line, asynchronous, idle high
- tx  out  1  UART transmit line, idle high
- cpu_hold  out  1  high = keep CPU in reset
- mem_addr  out  16  write address
- mem_data  out  8  write data
- mem_we_prg  out  1  one-cycle write strobe, PRG-ROM
- mem_we_chr  out  1  one-cycle write strobe, CHR-ROM
- mem_we_ram  out  1  one-cycle write strobe, CPU RAM
- busy  out  1  high while a frame is in progress

Behaviour:
- Reset values: tx=1, cpu_hold=1, mem_addr=0, mem_data=0, all mem_we_*=0, busy=0. Reset drops any frame and any TX byte in progress.
- RX path:
  - rx passes through a 2-FF synchronizer.
  - A falling edge while idle starts a bit counter. The start bit is re-checked at CLK_DIV/2; if high, it is a glitch and the receiver returns to idle.
  - Data bits are sampled every CLK_DIV, LSB first, then the stop bit.
  - Stop bit = 0 is a framing error: the byte is discarded and the frame FSM returns to IDLE.
  - A valid byte produces a one-cycle internal rx_valid.
- TX path: 8N1 at the same divider. Accepts a byte only when idle. A new response is never requested while TX is busy.
- Frame FSM states: IDLE, TARGET, ADDR_H, ADDR_L, LEN_H, LEN_L, DATA, CSUM, RESP.
  - IDLE:
    - byte 0xA5 -> TARGET.
    - byte 0x5A -> cpu_hold=0, send 0x4B.
    - byte 0x3C -> cpu_hold=1, send 0x4B.
    - any other byte is ignored.
  - TARGET: 0x00=PRG, 0x01=CHR, 0x02=RAM. Any other value -> send 0x45, go to IDLE.
  - ADDR_H, ADDR_L: load the 16-bit start address.
  - LEN_H, LEN_L: load the 16-bit count N. N=0 skips DATA and goes straight to CSUM.
  - DATA:
    - Each byte drives mem_data and mem_addr.
    - The selected mem_we_* pulses exactly one cycle, the cycle after rx_valid.
    - The 8-bit checksum accumulates modulo 256, the address increments, the counter decrements.
    - The address wraps 0xFFFF -> 0x0000.
    - Writes are not retracted on a later checksum failure.
  - CSUM: received byte equals the sum -> send 0x4B ('K'); otherwise send 0x45 ('E'). Then RESP.
  - RESP: wait for TX idle -> IDLE.
- Addresses are passed unmasked. Top level uses the low 12 bits for PRG/CHR and the low 11 bits for RAM.
- busy=1 in every state except IDLE.
- Timeout: a counter resets on each rx_valid. If it reaches TIMEOUT in any state other than IDLE or RESP, the FSM returns to IDLE silently. No response is sent and cpu_hold is unchanged.
- cpu_hold is changed only by the 0x5A and 0x3C commands and by reset. A PRG/CHR/RAM load does not alter it.
- A byte arriving while in RESP is dropped.

Test Plan:
- Reset, then idle rx -> tx=1, cpu_hold=1, no mem_we_* strobe for 10000 cycles.
- Frame A5 00 01 00 00 03 11 22 33 66 -> mem_we_prg pulses 3 times (addr 0x0100/0x0101/0x0102, data 0x11/0x22/0x33), each strobe 1 cycle wide; tx returns 0x4B.
- Frame A5 01 FF FF 00 02 AA 55 00 (checksum wrong; correct is 0xFF) -> mem_we_chr at 0xFFFF then 0x0000; tx returns 0x45.
- Byte 0x5A -> cpu_hold falls to 0, tx 0x4B. Then byte 0x3C -> cpu_hold=1, tx 0x4B.
- Frame A5 00 00 00 00 05 01 02, then silence for TIMEOUT+10 cycles -> busy drops to 0, no tx byte. A following valid frame A5 02 00 10 00 01 7E 7E -> mem_we_ram at 0x0010 with data 0x7E; tx 0x4B.
- Corruption cases:
  - Stop bit forced low mid-frame -> FSM in IDLE, busy=0.
  - 1/4-bit low glitch on idle rx -> no byte received.
  - Reset asserted mid-DATA -> no further strobes, busy=0, cpu_hold=1.

Source files
------------

// File: rtl/serial_loader.sv
// serial_loader: UART-driven programmer that streams a cartridge image into
// PRG-ROM, CHR-ROM or CPU RAM and holds the CPU in reset while it does so.
//
// Internal handshakes:
//   rx_valid - one-cycle pulse from the receiver and rx_shift holds the byte
//              that cycle. There is no backpressure, so the consumer must take
//              the byte in that cycle.
//   tx_start - one-cycle request with tx_byte. The transmitter accepts it only
//              while tx_busy is low. The frame FSM raises it only when the
//              transmitter is idle and then parks in RESP until tx_busy falls.
module serial_loader #(
    parameter int CLK_DIV = 217,
    parameter int TIMEOUT = 2500000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx,
    output logic        tx,
    output logic        cpu_hold,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_data,
    output logic        mem_we_prg,
    output logic        mem_we_chr,
    output logic        mem_we_ram,
    output logic        busy,
    output logic [3:0]  frame_state
);
    localparam int CW = $clog2(CLK_DIV + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [3:0] {
        S_IDLE, S_TARGET, S_ADDR_H, S_ADDR_L, S_LEN_H, S_LEN_L, S_DATA, S_CSUM, S_RESP
    } state_t;

    // receiver
    rx_state_t       rx_state;
    logic            rx_meta, rx_sync, rx_prev;
    logic [CW-1:0]   rx_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      rx_shift;
    logic            rx_valid, rx_err;

    // transmitter
    logic            tx_busy, tx_start;
    logic [7:0]      tx_byte;
    logic [8:0]      tx_shift;
    logic [3:0]      tx_bits;
    logic [CW-1:0]   tx_cnt;

    // frame FSM
    state_t          state;
    logic [1:0]      target;
    logic [15:0]     addr, count;
    logic [7:0]      csum;
    logic [TW-1:0]   to_cnt;

    assign busy        = (state != S_IDLE);
    assign frame_state = state;

    // RX: 2-FF synchronizer, start-bit glitch filter, LSB-first 8N1 sampling
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            bit_idx  <= '0;
            rx_shift <= '0;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
        end else begin
            rx_meta  <= rx;
            rx_sync  <= rx_meta;
            rx_prev  <= rx_sync;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        rx_state <= RX_START;
                        rx_cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt <= '0;
                        if (rx_sync) begin
                            rx_state <= RX_IDLE;
                        end else begin
                            rx_state <= RX_DATA;
                            bit_idx  <= '0;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == DIV_LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        bit_idx  <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) rx_state <= RX_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == DIV_LAST) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_IDLE;
                        if (rx_sync) rx_valid <= 1'b1;
                        else         rx_err   <= 1'b1;
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // TX: 8N1 shifter; start bit is driven on accept, then data LSB first, then stop
    always_ff @(posedge clock) begin
        if (reset) begin
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
            tx_shift <= '1;
            tx_bits  <= '0;
            tx_cnt   <= '0;
        end else if (!tx_busy) begin
            if (tx_start) begin
                tx_busy  <= 1'b1;
                tx       <= 1'b0;
                tx_shift <= {1'b1, tx_byte};
                tx_bits  <= '0;
                tx_cnt   <= '0;
            end
        end else if (tx_cnt == DIV_LAST) begin
            tx_cnt <= '0;
            if (tx_bits == 4'd9) begin
                tx_busy <= 1'b0;
            end else begin
                tx       <= tx_shift[0];
                tx_shift <= {1'b1, tx_shift[8:1]};
                tx_bits  <= tx_bits + 4'd1;
            end
        end else begin
            tx_cnt <= tx_cnt + CW'(1);
        end
    end

    // Frame FSM: command decode, header capture, memory writes, checksum, response
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            cpu_hold   <= 1'b1;
            mem_addr   <= '0;
            mem_data   <= '0;
            mem_we_prg <= 1'b0;
            mem_we_chr <= 1'b0;
            mem_we_ram <= 1'b0;
            tx_start   <= 1'b0;
            tx_byte    <= '0;
            target     <= '0;
            addr       <= '0;
            count      <= '0;
            csum       <= '0;
            to_cnt     <= '0;
        end else begin
            mem_we_prg <= 1'b0;
            mem_we_chr <= 1'b0;
            mem_we_ram <= 1'b0;
            tx_start   <= 1'b0;

            // inter-byte watchdog, only meaningful while a frame is open
            if (rx_valid || state == S_IDLE || state == S_RESP) to_cnt <= '0;
            else if (to_cnt != TO_LAST)                           to_cnt <= to_cnt + TW'(1);

            if (state != S_IDLE && state != S_RESP && (to_cnt == TO_LAST || rx_err)) begin
                // abandoned or corrupted frame: drop silently, cpu_hold untouched
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: if (rx_valid) begin
                        if (rx_shift == 8'hA5) begin
                            state <= S_TARGET;
                            csum  <= '0;
                        end else if (rx_shift == 8'h5A || rx_shift == 8'h3C) begin
                            cpu_hold <= (rx_shift == 8'h3C);
                            tx_byte  <= 8'h4B;
                            tx_start <= 1'b1;
                            state    <= S_RESP;
                        end
                    end
                    S_TARGET: if (rx_valid) begin
                        if (rx_shift <= 8'h02) begin
                            target <= rx_shift[1:0];
                            state  <= S_ADDR_H;
                        end else begin
                            tx_byte  <= 8'h45;
                            tx_start <= 1'b1;
                            state    <= S_RESP;
                        end
                    end
                    S_ADDR_H: if (rx_valid) begin
                        addr[15:8] <= rx_shift;
                        state      <= S_ADDR_L;
                    end
                    S_ADDR_L: if (rx_valid) begin
                        addr[7:0] <= rx_shift;
                        state     <= S_LEN_H;
                    end
                    S_LEN_H: if (rx_valid) begin
                        count[15:8] <= rx_shift;
                        state       <= S_LEN_L;
                    end
                    S_LEN_L: if (rx_valid) begin
                        count[7:0] <= rx_shift;
                        state      <= ({count[15:8], rx_shift} == 16'h0000) ? S_CSUM : S_DATA;
                    end
                    S_DATA: if (rx_valid) begin
                        mem_addr   <= addr;
                        mem_data   <= rx_shift;
                        mem_we_prg <= (target == 2'd0);
                        mem_we_chr <= (target == 2'd1);
                        mem_we_ram <= (target == 2'd2);
                        csum       <= csum + rx_shift;
                        addr       <= addr + 16'd1;
                        count      <= count - 16'd1;
                        if (count == 16'd1) state <= S_CSUM;
                    end
                    S_CSUM: if (rx_valid) begin
                        tx_byte  <= (rx_shift == csum) ? 8'h4B : 8'h45;
                        tx_start <= 1'b1;
                        state    <= S_RESP;
                    end
                    S_RESP: begin
                        // bytes arriving here are dropped; wait for the response to drain
                        if (!tx_busy && !tx_start) state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule
